// File: rtl/xor_encrypt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xor_encrypt_pkg
// Purpose  : Widths shared with the xor_encrypt core and the scheduler states.
// Revision : 1.0
// ============================================================================
package xor_encrypt_pkg;

    localparam int CODE_W = 256;
    localparam int KEY_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/xor_encrypt_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int idx;

    // Scan farthest-first so the candidate nearest to ptr is written last and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/xor_encrypt_sched.sv
`default_nettype none
// ============================================================================
// Module   : xor_encrypt_sched
// Purpose  : Round-robin scheduler sharing one xor_encrypt core, with watchdog.
// Revision : 1.0
// ============================================================================
module xor_encrypt_sched #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = xor_encrypt_pkg::CODE_W,
    parameter int KEY_W   = xor_encrypt_pkg::KEY_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*KEY_W-1:0]  req_key,
    input  logic [NUM_REQ*CODE_W-1:0] req_code,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [CODE_W-1:0]         rsp_code,
    output logic                      core_valid_in,
    output logic [KEY_W-1:0]          core_key,
    output logic [CODE_W-1:0]         core_code,
    input  logic [CODE_W-1:0]         core_code_out,
    input  logic                      core_valid_out,
    output logic                      busy,
    output logic                      err_timeout
);
    import xor_encrypt_pkg::*;

    localparam int                c_idx_w    = $clog2(NUM_REQ);
    localparam int                c_wd_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_wd_w-1:0]  c_wd_limit = c_wd_w'(TIMEOUT - 1);

    sched_state_t        r_state;
    logic [c_idx_w-1:0]  r_ptr;
    logic [c_idx_w-1:0]  r_id;
    logic [c_wd_w-1:0]   r_wd;
    logic [KEY_W-1:0]    r_key;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_result;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [c_idx_w-1:0]  w_grant_idx;
    logic                w_any;
    logic [c_idx_w-1:0]  w_next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    // Explicit wrap keeps non-power-of-two requester counts in range.
    assign w_next_ptr = (r_id == c_last_idx) ? '0 : r_id + c_idx_w'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_wd     <= '0;
            r_key    <= '0;
            r_code   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_key   <= req_key[w_grant_idx*KEY_W +: KEY_W];
                        r_code  <= req_code[w_grant_idx*CODE_W +: CODE_W];
                        r_id    <= w_grant_idx;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (core_valid_out) begin
                        r_result <= core_code_out;
                        r_state  <= RESP;
                    end else if (r_wd == c_wd_limit) begin
                        r_err   <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end else begin
                        r_wd <= r_wd + c_wd_w'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[r_id]) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by rst so every output reads zero for the whole reset pulse.
    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;

    always_comb begin
        rsp_valid = '0;
        if (r_state == RESP) begin
            rsp_valid[r_id] = 1'b1;
        end
    end

    assign rsp_code      = r_result;
    assign core_valid_in = (r_state == ISSUE);
    assign core_key      = r_key;
    assign core_code     = r_code;
    assign busy          = (r_state != IDLE);
    assign err_timeout   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xor_encrypt_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xor_encrypt_sched
// Purpose  : Transaction-level model plus stub core driving xor_encrypt_sched.
// Revision : 1.0
// ============================================================================
module tb_xor_encrypt_sched;

    localparam int N  = 4;
    localparam int CW = 256;
    localparam int KW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*KW-1:0] req_key = '0;
    logic [N*CW-1:0] req_code = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [CW-1:0]   rsp_code;
    logic            core_valid_in;
    logic [KW-1:0]   core_key;
    logic [CW-1:0]   core_code;
    logic [CW-1:0]   core_code_out = '0;
    logic            core_valid_out = 1'b0;
    logic            busy;
    logic            err_timeout;

    always #5 clk = ~clk;

    xor_encrypt_sched #(
        .NUM_REQ (N),
        .CODE_W  (CW),
        .KEY_W   (KW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_key        (req_key),
        .req_code       (req_code),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_code       (rsp_code),
        .core_valid_in  (core_valid_in),
        .core_key       (core_key),
        .core_code      (core_code),
        .core_code_out  (core_code_out),
        .core_valid_out (core_valid_out),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] golden(input logic [KW-1:0] k, input logic [CW-1:0] c);
        return c ^ {(CW/KW){k}};
    endfunction

    function automatic logic [CW-1:0] rand_code();
        logic [CW-1:0] v;
        for (int i = 0; i < CW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction model: age = cycles elapsed since the accept cycle.
    bit            m_active, m_resp, m_err;
    int            m_age, m_owner, m_ptr;
    logic [KW-1:0] m_key;
    logic [CW-1:0] m_code, m_result;

    task automatic model_reset();
        m_active = 0; m_resp = 0; m_err = 0;
        m_age = 0; m_owner = 0; m_ptr = 0;
        m_key = '0; m_code = '0; m_result = '0;
    endtask

    int            acc_cyc_q[$], acc_idx_q[$], cvi_cyc_q[$], rsp_cyc_q[$], rsp_own_q[$];
    logic [KW-1:0] cvi_key_q[$];
    logic [CW-1:0] rsp_code_q[$];

    task automatic clear_logs();
        acc_cyc_q.delete(); acc_idx_q.delete(); cvi_cyc_q.delete(); cvi_key_q.delete();
        rsp_cyc_q.delete(); rsp_own_q.delete(); rsp_code_q.delete();
    endtask

    int            cyc = 0;
    int            cw;
    logic [N-1:0]  exp_rr, exp_rv, prev_rv = '0;
    logic          prev_cvi = 1'b0;
    logic [KW-1:0] prev_key = '0;
    logic [CW-1:0] prev_code = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) model_reset();
        exp_rr = '0;
        if (!m_active && !rst) begin
            cw = pick(req_valid, m_ptr);
            if (cw >= 0) exp_rr[cw] = 1'b1;
        end
        exp_rv = '0;
        if (m_active && m_resp) exp_rv[m_owner] = 1'b1;
        chk("req_ready",     CW'(req_ready),     CW'(exp_rr));
        chk("rsp_valid",     CW'(rsp_valid),     CW'(exp_rv));
        chk("rsp_code",      rsp_code,           m_result);
        chk("core_valid_in", CW'(core_valid_in), CW'(m_active && !m_resp && m_age == 1));
        chk("core_key",      CW'(core_key),      CW'(m_key));
        chk("core_code",     core_code,          m_code);
        chk("busy",          CW'(busy),          CW'(m_active));
        chk("err_timeout",   CW'(err_timeout),   CW'(m_err));

        if (!rst && |(req_valid & req_ready)) begin
            acc_cyc_q.push_back(cyc); acc_idx_q.push_back(onehot_idx(req_valid & req_ready));
        end
        if (core_valid_in) begin
            cvi_cyc_q.push_back(cyc); cvi_key_q.push_back(core_key);
        end
        if (rsp_valid != '0 && prev_rv == '0) begin
            rsp_cyc_q.push_back(cyc); rsp_own_q.push_back(onehot_idx(rsp_valid));
            rsp_code_q.push_back(rsp_code);
        end
        prev_rv   = rsp_valid;
        prev_cvi  = core_valid_in;
        prev_key  = core_key;
        prev_code = core_code;

        if (!rst) begin
            if (!m_active) begin
                cw = pick(req_valid, m_ptr);
                if (cw >= 0) begin
                    m_active = 1; m_resp = 0; m_age = 0; m_owner = cw;
                    m_key  = req_key[cw*KW +: KW];
                    m_code = req_code[cw*CW +: CW];
                end
            end else if (!m_resp) begin
                if (m_age >= 2 && core_valid_out) begin
                    m_result = core_code_out; m_resp = 1;
                end else if (m_age == 1 + TO) begin
                    m_err = 1; m_ptr = (m_owner + 1) % N; m_active = 0;
                end
            end else if (rsp_ready[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_active = 0; m_resp = 0;
            end
            m_age++;
        end
    end

    // Stub core: answers a core_valid_in after a random delay, may drop it.
    bit            core_alive = 1, spur_en = 0;
    int            core_max_delay = 1, drop_pct = 0, pend = -1;
    logic [CW-1:0] pend_code = '0;

    task automatic drive_core();
        core_valid_out = 1'b0;
        if (prev_cvi && core_alive && int'($urandom_range(0, 99)) >= drop_pct) begin
            pend      = (core_max_delay > 1) ? int'($urandom_range(1, core_max_delay)) : 1;
            pend_code = golden(prev_key, prev_code);
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                core_valid_out = 1'b1; core_code_out = pend_code; pend = -1;
            end
        end else if (spur_en && !m_active && $urandom_range(0, 3) == 0) begin
            core_valid_out = 1'b1; core_code_out = rand_code();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_core();
    endtask

    task automatic do_reset();
        rst = 1'b1; pend = -1; req_valid = '0; rsp_ready = '0; core_valid_out = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got timeout want finish");
        $fatal(1);
    end

    int k;

    initial begin
        model_reset();
        // Single request from requester 2.
        do_reset(); clear_logs();
        req_key[2*KW +: KW] = 8'hA5; req_code[2*CW +: CW] = 256'h1;
        rsp_ready = 4'b0100; req_valid = 4'b0100;
        #1 chk("t1_req_ready", CW'(req_ready), CW'(4'b0100));
        step(); req_valid = '0;
        repeat (6) step();
        chk_int("t1_n_acc", acc_idx_q.size(), 1);
        chk_int("t1_n_rsp", rsp_cyc_q.size(), 1);
        if (acc_idx_q.size() > 0 && cvi_cyc_q.size() > 0 && rsp_cyc_q.size() > 0) begin
            chk_int("t1_acc_idx", acc_idx_q[0], 2);
            chk_int("t1_cvi_lat", cvi_cyc_q[0] - acc_cyc_q[0], 1);
            chk("t1_core_key", CW'(cvi_key_q[0]), CW'(8'hA5));
            chk_int("t1_rsp_lat", rsp_cyc_q[0] - acc_cyc_q[0], 3);
            chk_int("t1_rsp_own", rsp_own_q[0], 2);
            chk("t1_rsp_code", rsp_code_q[0], {{31{8'hA5}}, 8'hA4});
        end

        // Fairness with all requesters pending.
        do_reset(); clear_logs();
        req_valid = 4'hF; rsp_ready = 4'hF;
        repeat (20) step();
        req_valid = '0;
        chk_int("t2_n_acc_ge5", int'(acc_idx_q.size() >= 5), 1);
        if (acc_idx_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk_int($sformatf("t2_grant%0d", i), acc_idx_q[i], i % 4);
            for (int i = 1; i < 5; i++) chk_int($sformatf("t2_gap%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 4);
        end
        repeat (6) step();

        // Backpressure on requester 1.
        do_reset(); clear_logs();
        req_key[1*KW +: KW] = 8'h3C; req_code[1*CW +: CW] = 256'hDEADBEEF;
        req_valid = 4'b0010;
        step(); req_valid = 4'b1101; rsp_ready = 4'b1101;
        k = 0;
        while (rsp_valid[1] !== 1'b1 && k < 10) begin step(); k++; end
        chk_int("t3_rsp_seen", int'(rsp_valid[1] === 1'b1), 1);
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("t3_hold_valid", CW'(rsp_valid), CW'(4'b0010));
            chk("t3_hold_code", rsp_code, {{28{8'h3C}}, 32'hE29182D3});
            chk("t3_hold_ready", CW'(req_ready), CW'(0));
        end
        step(); rsp_ready = 4'b0010; #1;
        chk("t3_hs_valid", CW'(rsp_valid), CW'(4'b0010));
        step(); #1;
        chk("t3_done_valid", CW'(rsp_valid), CW'(0));
        chk("t3_next_ready", CW'(req_ready), CW'(4'b0100));
        req_valid = '0; rsp_ready = 4'hF;
        repeat (8) step();

        // Watchdog abort with a dead core.
        do_reset(); clear_logs();
        core_alive = 0; rsp_ready = 4'hF; req_valid = 4'b0100;
        step(); req_valid = 4'b1000;
        k = 0;
        while (acc_idx_q.size() < 2 && k < 40) begin step(); k++; end
        req_valid = '0;
        chk_int("t4_n_acc", acc_idx_q.size(), 2);
        if (acc_idx_q.size() >= 2) begin
            chk_int("t4_next_idx", acc_idx_q[1], 3);
            chk_int("t4_gap", acc_cyc_q[1] - acc_cyc_q[0], 18);
        end
        #1 chk("t4_err", CW'(err_timeout), CW'(1));
        repeat (25) step();
        chk("t4_err_sticky", CW'(err_timeout), CW'(1));
        chk_int("t4_no_rsp", rsp_cyc_q.size(), 0);

        // Reset in the middle of WAIT.
        do_reset(); core_alive = 1; rsp_ready = 4'hF;
        req_key[0 +: KW] = 8'h5A; req_code[0 +: CW] = '0;
        req_valid = 4'b0010; step(); req_valid = '0;
        repeat (6) step();
        core_alive = 0; req_valid = 4'b0100; step();
        req_valid = '0; step();
        rst = 1'b1; pend = -1; #1;
        chk("t5_busy", CW'(busy), CW'(0));
        chk("t5_cvi", CW'(core_valid_in), CW'(0));
        chk("t5_rsp_valid", CW'(rsp_valid), CW'(0));
        chk("t5_rsp_code", rsp_code, '0);
        chk("t5_core_key", CW'(core_key), CW'(0));
        chk("t5_core_code", core_code, '0);
        chk("t5_err", CW'(err_timeout), CW'(0));
        step(); step(); rst = 1'b0;
        clear_logs(); core_alive = 1; req_valid = 4'b0101;
        step(); req_valid = '0;
        repeat (6) step();
        chk_int("t5_n_acc", acc_idx_q.size(), 1);
        if (acc_idx_q.size() > 0) chk_int("t5_first_grant", acc_idx_q[0], 0);
        chk_int("t5_n_rsp", rsp_own_q.size(), 1);
        if (rsp_own_q.size() > 0) chk_int("t5_rsp_own", rsp_own_q[0], 0);

        // Spurious core answers while idle.
        for (int i = 0; i < 4; i++) begin
            step(); core_valid_out = 1'b1; core_code_out = rand_code(); #1;
            chk("t6_busy", CW'(busy), CW'(0));
            chk("t6_rsp_valid", CW'(rsp_valid), CW'(0));
        end
        step(); #1;
        chk("t6_result_kept", rsp_code, {32{8'h5A}});

        // Randomized traffic.
        spur_en = 1; core_alive = 1; core_max_delay = 4; drop_pct = 8;
        for (int c = 0; c < 700; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_key[i*KW +: KW] = KW'($urandom);
                    req_code[i*CW +: CW] = rand_code();
                end
            end
            step();
        end
        spur_en = 0;
        do_reset();
        repeat (3) step();
        chk("final_err_cleared", CW'(err_timeout), CW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xor_encrypt_sched.md
# xor_encrypt_sched

Round-robin scheduler sharing one `xor_encrypt` core among `NUM_REQ` requesters. Each requester submits a (key, code) pair over a valid/ready handshake. The scheduler accepts the pair, issues it to the core as a one-cycle `valid_in` pulse, and captures the core result. It then returns the result to the originating requester over a per-requester response handshake. A watchdog flags a core that never answers.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `CODE_W`, 256: code width; must match the core.
- `KEY_W`, 8: key width; must match the core.
- `TIMEOUT`, 16: cycles in WAIT without `core_valid_out` before abort; ≥2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_ready` out NUM_REQ: one-hot accept strobe.
- `req_key` in NUM_REQ×KEY_W: per-requester key.
- `req_code` in NUM_REQ×CODE_W: per-requester plaintext.
- `rsp_valid` out NUM_REQ: one-hot, result available.
- `rsp_ready` in NUM_REQ: requester takes result.
- `rsp_code` out CODE_W: shared result bus, qualified by `rsp_valid`.
- `core_valid_in` out 1: to core `valid_in`.
- `core_key` out KEY_W: to core `key`.
- `core_code` out CODE_W: to core `code`.
- `core_code_out` in CODE_W: from core `code_out`.
- `core_valid_out` in 1: from core `valid_out`.
- `busy` out 1: state ≠ IDLE.
- `err_timeout` out 1: sticky; cleared only by `rst`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid`, the arbiter picks the first set bit at or after `rr_ptr`, cyclically.
  - `req_ready[win]`=1 combinationally in that cycle.
  - At the edge: capture `req_key`/`req_code` of `win` and `id`=win, then go to ISSUE.
  - No `req_valid` → stay in IDLE.
- **ISSUE**: `core_valid_in`=1 for exactly one cycle, with `core_key`/`core_code` driven from the capture registers. Clear the watchdog; go to WAIT.
- **WAIT**
  - On `core_valid_out`: capture `core_code_out` into the result register, then go to RESP.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT`:
    - set `err_timeout`;
    - set `rr_ptr`=id+1 mod NUM_REQ;
    - go to IDLE with no response (the transaction is dropped).
- **RESP**
  - `rsp_valid[id]`=1 and `rsp_code`=result; both held stable until `rsp_ready[id]`.
  - On handshake: `rr_ptr`=id+1 mod NUM_REQ, go to IDLE.
  - `rsp_ready` of other requesters is ignored.
- Outside ISSUE, `core_valid_in`=0 and `core_key`/`core_code` hold the last captured value.
- `core_valid_out` outside WAIT is ignored.
- Exactly one transaction is in flight; `req_ready` is 0 in every state except IDLE.
- Pointer wrap: `rr_ptr` counts modulo NUM_REQ. For non-power-of-2 NUM_REQ, NUM_REQ−1 wraps explicitly to 0.
- Reset values:
  - state = IDLE; `rr_ptr`, `id`, watchdog, capture and result registers = 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `core_valid_in`, `busy`, `err_timeout`, `rsp_code`, `core_key`, `core_code`.
- Reset mid-transaction drops it silently; no `rsp_valid` is ever issued for it.

## Timing
- Request accepted at cycle T (`req_valid & req_ready` high).
- `core_valid_in` at T+1.
- Core answers at T+2 (core latency 1).
- `rsp_valid` at T+3 earliest; with immediate `rsp_ready`, the next accept is at T+4.
- Peak throughput: one transaction per 4 cycles.
- Timeout: `err_timeout` rises at the edge ending cycle T+1+TIMEOUT; `busy` falls the same edge.
- A simultaneous `rsp_ready` handshake and new `req_valid` cannot overlap: the new request is accepted in the following IDLE cycle.
- `req_ready` depends combinationally on `req_valid` and state only. All other outputs are registered or decoded from state.

## Structure
- Package `xor_encrypt_pkg`:
  - `CODE_W` and `KEY_W` constants, shared with the core;
  - `sched_state_t` enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module `rr_arbiter`: parameterised NUM_REQ; inputs `req` and `ptr`; outputs one-hot `grant`, `grant_idx`, `any`. Purely combinational.
- The FSM, capture/result registers and watchdog live in the top module.
- The `xor_encrypt` core is instantiated by the parent, not inside this block.

## Test plan
- **Single request:** after reset, `req_valid[2]`=1, `req_key`=8'hA5, code=256'h1.
  - `req_ready[2]` at T; `core_valid_in` at T+1 with `core_key`=8'hA5.
  - `rsp_valid[2]` at T+3; `rsp_code` equals the golden-model core output.
- **Fairness:** all four `req_valid` held high from reset with `rsp_ready`=4'hF.
  - Grant order 0,1,2,3,0; accepts exactly 4 cycles apart.
- **Backpressure:** `rsp_ready[1]` held low 5 cycles during RESP.
  - `rsp_valid[1]` and `rsp_code` stay stable; `req_ready`=0 throughout.
  - Completes on the cycle `rsp_ready[1]` rises.
- **Timeout:** stub core never asserts `valid_out`, TIMEOUT=16.
  - `err_timeout`=1 at T+17; no `rsp_valid`; the next request (requester 3) is accepted.
  - `err_timeout` stays 1 until `rst`.
- **Reset mid-WAIT:** assert `rst` at T+2.
  - All outputs are 0 immediately (asynchronous).
  - After release, a request from requester 0 is granted first; no stale `rsp_valid`.
- **Spurious core answer:** pulse `core_valid_out` while in IDLE with a value on `core_code_out`.
  - No state change; no `rsp_valid`; the result register is unchanged.
